shift_collect8_ctrl: RTL and testbench

SHIFT_COLLECT8_CTRL -- requirements
Module: shift_collect8_ctrl

---
 rtl/shift_collect8_ctrl.sv | 105 ++++++++++
 tb/tb_shift_collect8_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/shift_collect8_ctrl.sv
// Serial-to-parallel collector: gathers 8 complex samples into one packed frame.
// State register, lane counter and collect buffer are separate from the output frame registers.
module shift_collect8_ctrl #(
  parameter int DW = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sclr,
  input  logic            sof,
  input  logic            din_valid,
  input  logic [DW-1:0]   dinre,
  input  logic [DW-1:0]   dinim,
  output logic [8*DW-1:0] doutre,
  output logic [8*DW-1:0] doutim,
  output logic            dout_valid,
  output logic            frame_err,
  output logic            busy
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [8*DW-1:0] buf_re_q, buf_re_d;
  logic [8*DW-1:0] buf_im_q, buf_im_d;
  logic [8*DW-1:0] doutre_q, doutre_d;
  logic [8*DW-1:0] doutim_q, doutim_d;
  logic            dout_valid_q, dout_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_re_d     = buf_re_q;
    buf_im_d     = buf_im_q;
    doutre_d     = doutre_q;
    doutim_d     = doutim_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (sclr) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else if (din_valid) begin
      if (sof) begin
        // a sof inside a partial frame restarts collection at lane 0
        buf_re_d[DW-1:0] = dinre;
        buf_im_d[DW-1:0] = dinim;
        cnt_d            = 3'd1;
        state_d          = FILL;
        frame_err_d      = (state_q == FILL);
      end else if (cnt_q == 3'd7) begin
        buf_re_d[7*DW +: DW] = dinre;
        buf_im_d[7*DW +: DW] = dinim;
        doutre_d     = {dinre, buf_re_q[7*DW-1:0]};
        doutim_d     = {dinim, buf_im_q[7*DW-1:0]};
        dout_valid_d = 1'b1;
        cnt_d        = 3'd0;
        state_d      = IDLE;
      end else begin
        buf_re_d[int'(cnt_q)*DW +: DW] = dinre;
        buf_im_d[int'(cnt_q)*DW +: DW] = dinim;
        cnt_d   = cnt_q + 3'd1;
        state_d = FILL;
      end
    end

    busy_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      buf_re_q     <= '0;
      buf_im_q     <= '0;
      doutre_q     <= '0;
      doutim_q     <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_re_q     <= buf_re_d;
      buf_im_q     <= buf_im_d;
      doutre_q     <= doutre_d;
      doutim_q     <= doutim_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign doutre     = doutre_q;
  assign doutim     = doutim_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_shift_collect8_ctrl.sv
// Directed bench for shift_collect8_ctrl; expected frames are built from hand-chosen sample ramps.
module tb_shift_collect8_ctrl;
  localparam int DW = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sclr;
  logic            sof;
  logic            din_valid;
  logic [DW-1:0]   dinre;
  logic [DW-1:0]   dinim;
  logic [8*DW-1:0] doutre;
  logic [8*DW-1:0] doutim;
  logic            dout_valid;
  logic            frame_err;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  shift_collect8_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .sof(sof), .din_valid(din_valid),
    .dinre(dinre), .dinim(dinim), .doutre(doutre), .doutim(doutim),
    .dout_valid(dout_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [8*DW-1:0] pack(input int b);
    logic [8*DW-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*DW +: DW] = DW'(b + k);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [8*DW-1:0] obs, input logic [8*DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input int re, input int im, input logic s);
    logic [31:0] rv, iv;
    rv = re;
    iv = im;
    din_valid = 1'b1;
    sof       = s;
    dinre     = rv[DW-1:0];
    dinim     = iv[DW-1:0];
    @(posedge clk); #1;
    din_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; sclr = 1'b0; sof = 1'b0; din_valid = 1'b0; dinre = '0; dinim = '0;
    #3;
    chk("rst_doutre", doutre, '0);
    chk("rst_doutim", doutim, '0);
    chk("rst_valid", 80'(dout_valid), 80'(0));
    chk("rst_ferr", 80'(frame_err), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    @(posedge clk); #4;
    rst_n = 1'b1;
    idle();

    // basic frame
    for (int i = 0; i < 8; i++) begin
      send(2 + i, 1 + i, 1'b0);
      if (i == 0) chk("basic_busy_first", 80'(busy), 80'(1));
      if (i == 6) chk("basic_valid_early", 80'(dout_valid), 80'(0));
    end
    chk("basic_valid", 80'(dout_valid), 80'(1));
    chk("basic_re", doutre, pack(2));
    chk("basic_im", doutim, pack(1));
    chk("basic_busy_fall", 80'(busy), 80'(0));
    idle();
    chk("basic_valid_pulse", 80'(dout_valid), 80'(0));
    chk("basic_hold", doutre, pack(2));

    // gapped input
    for (int i = 0; i < 8; i++) begin
      send(2 + i, 1 + i, 1'b0);
      if (i == 2 || i == 5) begin
        idle();
        chk("gap_busy", 80'(busy), 80'(1));
        chk("gap_no_valid", 80'(dout_valid), 80'(0));
      end
    end
    chk("gap_valid", 80'(dout_valid), 80'(1));
    chk("gap_re", doutre, pack(2));
    chk("gap_im", doutim, pack(1));
    idle();

    // resync with sof mid-frame
    for (int i = 0; i < 5; i++) send(100 + i, 500 + i, 1'b0);
    send(10, 30, 1'b1);
    chk("resync_ferr", 80'(frame_err), 80'(1));
    chk("resync_busy", 80'(busy), 80'(1));
    for (int i = 1; i < 8; i++) begin
      send(10 + i, 30 + i, 1'b0);
      if (i == 1) chk("resync_ferr_once", 80'(frame_err), 80'(0));
      if (i == 6) chk("resync_no_early", 80'(dout_valid), 80'(0));
    end
    chk("resync_valid", 80'(dout_valid), 80'(1));
    chk("resync_re", doutre, pack(10));
    chk("resync_im", doutim, pack(30));
    idle();

    // synchronous clear, with din_valid also high to exercise priority
    for (int i = 0; i < 4; i++) send(40 + i, 40 + i, 1'b0);
    sclr = 1'b1;
    send(99, 99, 1'b1);
    sclr = 1'b0;
    chk("clr_busy", 80'(busy), 80'(0));
    chk("clr_ferr", 80'(frame_err), 80'(0));
    chk("clr_valid", 80'(dout_valid), 80'(0));
    chk("clr_hold", doutre, pack(10));
    for (int i = 0; i < 8; i++) begin
      send(20 + i, 60 + i, 1'b0);
      if (i == 0) chk("clr_first_ferr", 80'(frame_err), 80'(0));
      if (i == 6) chk("clr_hold_partial", doutre, pack(10));
    end
    chk("clr_valid_frame", 80'(dout_valid), 80'(1));
    chk("clr_re", doutre, pack(20));
    chk("clr_im", doutim, pack(60));
    idle();

    // streaming 24 back-to-back samples
    for (int i = 0; i < 24; i++) begin
      send(i, 200 + i, 1'b0);
      chk("stream_valid", 80'(dout_valid), 80'((i % 8) == 7));
      if ((i % 8) == 7) begin
        chk("stream_re", doutre, pack(i - 7));
        chk("stream_im", doutim, pack(200 + i - 7));
      end
    end
    idle();

    // asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) send(300 + i, 300 + i, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_doutre", doutre, '0);
    chk("mrst_doutim", doutim, '0);
    chk("mrst_busy", 80'(busy), 80'(0));
    chk("mrst_valid", 80'(dout_valid), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    send(70, 80, 1'b1);
    chk("mrst_sof_idle_ferr", 80'(frame_err), 80'(0));
    for (int i = 1; i < 8; i++) send(70 + i, 80 + i, 1'b0);
    chk("mrst_valid_frame", 80'(dout_valid), 80'(1));
    chk("mrst_re", doutre, pack(70));
    chk("mrst_im", doutim, pack(80));
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
